fft_stage_mux: RTL and testbench
================================

# fft_stage_mux

Parametrised FFT stage data selector: chooses per beat between two lane-parallel butterfly paths (A/B). Over a programmable window of consecutive beats it also gathers one lane of a third path, one sample per beat, into a parallel vector. It then injects that vector on the beat immediately after the window. It sits between butterfly stages of the FFT datapath and replaces the fixed-size 4×34-bit selector with a phase-counted, stallable, frame-synchronised block.

## Interface
Parameters:
- LANES, 4, number of parallel lanes per beat (≥2)
- W, 34, bits per lane sample
- FRAME_LOG2, 4, log2 of frame length F in beats; LANES < F required
- CAP_START, 14, frame phase of the first gather beat (0..F-1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid; phase advances only on valid beats
- frame_sync  in  1  qualifies the current valid beat as phase 0
- sel  in  1  1 → data_a, 0 → data_b on non-inject beats
- data_a  in  LANES*W  path A, lane k at [k*W +: W]
- data_b  in  LANES*W  path B
- data_c  in  LANES*W  gather source path
- cap_lane  in  $clog2(LANES)  lane of data_c to gather; sampled per beat
- out_valid  out  1  output beat valid
- data_out  out  LANES*W  selected or injected vector
- inject  out  1  data_out carries gathered vector this beat
- phase  out  FRAME_LOG2  phase of the beat presented on data_out

## Operation
- Phase counter ph (FRAME_LOG2 bits, wraps F-1→0). The current beat's phase is 0 if frame_sync is set, else ph. On a valid beat, ph ← current phase + 1 (mod F). Invalid beats: ph, gather buffer and mask hold; frame_sync is ignored.
- Gather window: valid beats with current phase = (CAP_START+k) mod F, k = 0..LANES-1. On such a beat, g[k] ← data_c lane cap_lane and mask[k] ← 1. For k = 0, mask is cleared first, so mask = 1 after that beat.
- Inject beat: valid beat with current phase = IP = (CAP_START+LANES) mod F. If mask is all ones, data_out = {g[LANES-1],…,g[0]}, inject = 1, and mask ← 0. Otherwise the beat falls back to the normal selection with inject = 0.
- All other beats: data_out = sel ? data_a : data_b, inject = 0.
- A frame_sync beat clears mask before any capture on that same beat. This aborts a partial gather.
- Gather and inject phases never coincide, because LANES < F.
- Window wrap is supported, e.g. CAP_START=14, LANES=4, F=16 → capture phases 14, 15, 0, 1 and IP = 2.

## Timing
- Reset: ph = 0, mask = 0, g[*] = 0, out_valid = 0, inject = 0, data_out = 0, phase = 0.
- Reset asserted mid-gather discards the partial vector. The first inject after release requires a full window.
- Pipelined build: outputs are registered, latency 1 cycle from the input beat. out_valid, inject, phase and data_out are aligned.
- Combinational build: latency 0. out_valid = in_valid, and the remaining outputs are decoded from the current inputs and ph.
- No backpressure. The downstream stage must accept every out_valid beat.

## Configuration
- FFT_MUX_PIPE_EN defined: output register stage; all outputs are flops reset to 0; latency 1.
- FFT_MUX_PIPE_EN undefined: outputs are combinational, latency 0. The counter, gather buffer and mask remain registered, with identical reset behaviour.

## Structure
- Package fft_mux_pkg holds:
  - lane slice helper and lane vector typedef, parameterised via W and LANES
  - function for wrap-around phase arithmetic, (a+b) mod F
  - function for the gather-window hit test, returning the hit flag and k
- Sub-module fft_gather_buf holds the g[] registers, the mask, the capture decode and the full flag. The top level keeps the phase counter, the select/inject mux and the optional output register.

## Test plan
- Defaults, continuous valid, frame_sync on the first beat, data_c lane 0 = phase number, cap_lane = 0 → the beat at phase 2 outputs {1, 0, 15, 14}, inject = 1; all other beats follow sel.
- sel toggled each beat with data_a = 0xA…, data_b = 0xB… on non-inject phases → data_out alternates A/B, phase increments 0..15 and wraps.
- in_valid low for 3 cycles in the middle of the window (after phase 15) → ph holds; the inject beat still outputs the full vector with correct samples.
- frame_sync asserted at phase 15 (mid-window) → mask cleared; the next phase-2 beat outputs the sel path with inject = 0; the following frame injects normally.
- cap_lane = 3 with LANES = 8, W = 16, FRAME_LOG2 = 5, CAP_START = 28 → gathers lane 3 at phases 28..31 and 0..3, injects at phase 4.
- rst_n pulsed low asynchronously at phase 0 of the window → all outputs 0 immediately; no inject in the first frame after release without a full window.

Source files
------------

// File: rtl/fft_mux_pkg.sv
// fft_mux_pkg: shared types and helpers for the FFT stage selector.
//   lane_word_t / lane_vec_t : maximum-width carriers for one lane sample and
//                              one lane-parallel beat (W <= MAX_W and
//                              LANES*W <= MAX_VEC must hold).
//   lane_slice()             : extract lane 'lane' of width 'w' from a vector.
//   phase_add()              : (a + b) mod 2**flog2.
//   win_hit()                : gather-window hit test, returns hit and slot k.
package fft_mux_pkg;

  localparam int unsigned MAX_W   = 64;
  localparam int unsigned MAX_VEC = 1024;

  typedef logic [MAX_W-1:0]   lane_word_t;
  typedef logic [MAX_VEC-1:0] lane_vec_t;

  // The result carries the lane in its low bits; the caller truncates to W.
  function automatic lane_word_t lane_slice(input lane_vec_t vec,
                                            input int unsigned lane,
                                            input int unsigned w);
    lane_vec_t sh;
    sh = vec >> (lane * w);
    return sh[MAX_W-1:0];
  endfunction

  function automatic int unsigned phase_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned flog2);
    return (a + b) & ((32'd1 << flog2) - 32'd1);
  endfunction

  // k is the distance of 'cur' past the window start, taken modulo the frame
  // length so that windows wrapping through phase 0 need no special case.
  function automatic logic win_hit(input  int unsigned cur,
                                   input  int unsigned cap_start,
                                   input  int unsigned lanes,
                                   input  int unsigned flog2,
                                   output int unsigned k);
    k = (cur + (32'd1 << flog2) - cap_start) & ((32'd1 << flog2) - 32'd1);
    return (k < lanes);
  endfunction

endpackage

// File: rtl/fft_gather_buf.sv
// fft_gather_buf: gathers one lane of data_c per window beat into g[0..LANES-1]
// and tracks which slots are filled.
//   beat_valid : current beat is valid (state only changes on valid beats)
//   sync       : valid beat qualified by frame_sync; clears the mask first
//   cur_phase  : frame phase of the current beat
//   data_c     : gather source vector; lane cap_lane is sampled
//   take       : the top level consumes the vector this beat; clears the mask
//   g_vec      : {g[LANES-1], ..., g[0]}
//   full       : every slot of the current window has been captured
module fft_gather_buf
  import fft_mux_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int W          = 34,
  parameter int FRAME_LOG2 = 4,
  parameter int CAP_START  = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       beat_valid,
  input  logic                       sync,
  input  logic [FRAME_LOG2-1:0]      cur_phase,
  input  logic [LANES*W-1:0]         data_c,
  input  logic [$clog2(LANES)-1:0]   cap_lane,
  input  logic                       take,
  output logic [LANES*W-1:0]         g_vec,
  output logic                       full
);

  localparam int KW = $clog2(LANES);

  logic [LANES-1:0] mask;
  logic [LANES-1:0] mask_nx;
  logic [W-1:0]     g [LANES];
  logic             hit;
  int unsigned      k;
  logic [KW-1:0]    kk;
  logic [W-1:0]     sample;

  always_comb begin
    k       = 0;
    hit     = win_hit(32'(cur_phase), CAP_START, LANES, FRAME_LOG2, k);
    kk      = k[KW-1:0];
    sample  = W'(lane_slice(MAX_VEC'(data_c), 32'(cap_lane), W));
    mask_nx = mask;
    if (beat_valid) begin
      // Clearing precedes capture so slot 0 always opens a fresh window and a
      // sync beat inside a window drops the partial vector.
      if (sync || take || (hit && (k == 0))) mask_nx = '0;
      if (hit) mask_nx[kk] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      for (int i = 0; i < LANES; i++) g[i] <= '0;
    end else begin
      mask <= mask_nx;
      if (beat_valid && hit) g[kk] <= sample;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    assign g_vec[i*W +: W] = g[i];
  end

  assign full = &mask;

endmodule

// File: rtl/fft_stage_mux.sv
// fft_stage_mux: per-beat A/B lane-vector selector that injects a gathered
// vector of data_c samples on the beat following the gather window.
// Build option: FFT_MUX_PIPE_EN defined -> registered outputs, latency 1;
//               undefined -> combinational outputs, latency 0.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid           : input beat valid
//   frame_sync         : current valid beat is phase 0
//   sel                : 1 -> data_a, 0 -> data_b on non-inject beats
//   data_a/b/c         : lane-parallel paths, lane k at [k*W +: W]
//   cap_lane           : lane of data_c gathered this beat
//   out_valid          : output beat valid
//   data_out           : selected or injected vector
//   inject             : data_out carries the gathered vector
//   phase              : frame phase of the beat on data_out
// Handshake: valid-only. Every in_valid beat is accepted and produces exactly
// one out_valid beat; there is no ready, so downstream must take every beat.
module fft_stage_mux
  import fft_mux_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int W          = 34,
  parameter int FRAME_LOG2 = 4,
  parameter int CAP_START  = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     frame_sync,
  input  logic                     sel,
  input  logic [LANES*W-1:0]       data_a,
  input  logic [LANES*W-1:0]       data_b,
  input  logic [LANES*W-1:0]       data_c,
  input  logic [$clog2(LANES)-1:0] cap_lane,
  output logic                     out_valid,
  output logic [LANES*W-1:0]       data_out,
  output logic                     inject,
  output logic [FRAME_LOG2-1:0]    phase
);

  localparam logic [FRAME_LOG2-1:0] IP =
    FRAME_LOG2'(phase_add(CAP_START, LANES, FRAME_LOG2));

  logic [FRAME_LOG2-1:0] ph;
  logic [FRAME_LOG2-1:0] cur_ph;
  logic                  sync_q;
  logic                  inject_c;
  logic                  full;
  logic [LANES*W-1:0]    g_vec;
  logic [LANES*W-1:0]    sel_data;

  // frame_sync only counts on valid beats.
  assign sync_q   = in_valid & frame_sync;
  assign cur_ph   = sync_q ? '0 : ph;
  assign inject_c = in_valid && (cur_ph == IP) && full;
  assign sel_data = inject_c ? g_vec : (sel ? data_a : data_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= '0;
    end else if (in_valid) begin
      ph <= FRAME_LOG2'(phase_add(32'(cur_ph), 32'd1, FRAME_LOG2));
    end
  end

  fft_gather_buf #(
    .LANES      (LANES),
    .W          (W),
    .FRAME_LOG2 (FRAME_LOG2),
    .CAP_START  (CAP_START)
  ) u_gather (
    .clk        (clk),
    .rst_n      (rst_n),
    .beat_valid (in_valid),
    .sync       (sync_q),
    .cur_phase  (cur_ph),
    .data_c     (data_c),
    .cap_lane   (cap_lane),
    .take       (inject_c),
    .g_vec      (g_vec),
    .full       (full)
  );

`ifdef FFT_MUX_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inject    <= 1'b0;
      phase     <= '0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      inject    <= inject_c;
      phase     <= cur_ph;
      data_out  <= sel_data;
    end
  end
`else
  assign out_valid = in_valid;
  assign inject    = inject_c;
  assign phase     = cur_ph;
  assign data_out  = sel_data;
`endif

endmodule

// File: tb/tb_fft_stage_mux.sv
// tb_fft_stage_mux: randomized self-checking bench for fft_stage_mux with a
// frame-level reference model; a second instance covers the 8-lane case.
module tb_fft_stage_mux;

  localparam int L = 4, W = 34, F = 16, CS = 14, IP = 2, VW = L * W;
  localparam int L2 = 8, W2 = 16, F2 = 32, CS2 = 28, VW2 = L2 * W2;
`ifdef FFT_MUX_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT 1 (defaults) ----------------
  logic          in_valid, frame_sync, sel, out_valid, inject;
  logic [VW-1:0] data_a, data_b, data_c, data_out;
  logic [1:0]    cap_lane;
  logic [3:0]    phase;

  fft_stage_mux dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .frame_sync(frame_sync),
    .sel(sel), .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .cap_lane(cap_lane), .out_valid(out_valid), .data_out(data_out),
    .inject(inject), .phase(phase)
  );

  // ---------------- DUT 2 (8 lanes, 16 bit, F=32, start 28) ----------------
  logic           v2, fs2, s2, ov2, oi2;
  logic [VW2-1:0] a2, b2, c2, od2;
  logic [2:0]     cl2;
  logic [4:0]     oph2;

  fft_stage_mux #(.LANES(L2), .W(W2), .FRAME_LOG2(5), .CAP_START(CS2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .frame_sync(fs2), .sel(s2),
    .data_a(a2), .data_b(b2), .data_c(c2), .cap_lane(cl2),
    .out_valid(ov2), .data_out(od2), .inject(oi2), .phase(oph2)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Frame-level view: the window is the set of L phases starting at CS; a
  // vector is delivered at IP only if every slot of the latest window arrived.
  int         m_ph;
  logic [W-1:0] m_g [L];
  bit         m_have [L];

  task automatic model_reset();
    m_ph = 0;
    for (int i = 0; i < L; i++) begin m_g[i] = '0; m_have[i] = 1'b0; end
  endtask

  task automatic model_beat(input logic v, fs, s, input logic [VW-1:0] a, b, c,
                            input int cl, output logic ev, ei,
                            output logic [3:0] eph, output logic [VW-1:0] ed);
    int cur, k;
    bit all;
    cur = (v && fs) ? 0 : m_ph;
    ev = v; eph = 4'(cur); ei = 1'b0; ed = s ? a : b;
    if (v) begin
      all = 1'b1;
      for (int i = 0; i < L; i++) all &= m_have[i];
      if (cur == IP && all) begin
        ei = 1'b1;
        for (int i = 0; i < L; i++) ed[i*W +: W] = m_g[i];
      end
      if (fs || ei) for (int i = 0; i < L; i++) m_have[i] = 1'b0;
      k = (cur - CS + F) % F;
      if (k < L) begin
        if (k == 0) for (int i = 0; i < L; i++) m_have[i] = 1'b0;
        m_have[k] = 1'b1;
        m_g[k] = c[cl*W +: W];
      end
      m_ph = (cur + 1) % F;
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = (r << 32) | VW'($urandom());
    return r;
  endfunction

  // ---------------- driver ----------------
  // Entered at posedge+1; returns outputs for the beat at posedge+1 after it.
  task automatic drive_beat(input logic v, fs, s, input logic [VW-1:0] a, b, c,
                            input int cl, output logic ov, oi,
                            output logic [3:0] oph, output logic [VW-1:0] od);
    in_valid = v; frame_sync = fs; sel = s;
    data_a = a; data_b = b; data_c = c; cap_lane = 2'(cl);
    if (!PIPE) begin #2; ov = out_valid; oi = inject; oph = phase; od = data_out; end
    @(posedge clk); #1;
    if (PIPE) begin ov = out_valid; oi = inject; oph = phase; od = data_out; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; frame_sync = 0; sel = 0; data_a = '0; data_b = '0; data_c = '0;
    cap_lane = 0; v2 = 0; fs2 = 0; s2 = 0; a2 = '0; b2 = '0; c2 = '0; cl2 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (inject !== 1'b0) begin errors++; $display("FAIL reset_inject got %b want 0", inject); end
    checks++; if (phase !== 4'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_gather_basic();
    logic ov, oi, ev, ei, s, fs;
    logic [3:0] oph, eph;
    logic [VW-1:0] od, ed, a, b, c;
    logic [VW-1:0] exp_vec = {34'd1, 34'd0, 34'd15, 34'd14};
    for (int i = 0; i < 36; i++) begin
      fs = (i == 0); s = 1'($urandom_range(0, 1)); a = rand_vec(); b = rand_vec();
      c = rand_vec(); c[W-1:0] = W'(fs ? 0 : m_ph);
      model_beat(1'b1, fs, s, a, b, c, 0, ev, ei, eph, ed);
      drive_beat(1'b1, fs, s, a, b, c, 0, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL basic beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
      if (i == 18) begin
        checks++;
        if (oi !== 1'b1 || oph !== 4'd2 || od !== exp_vec) begin
          errors++; $display("FAIL basic_inject_vec got inj=%b ph=%0d d=%h want inj=1 ph=2 d=%h", oi, oph, od, exp_vec);
        end
      end
    end
  endtask

  task automatic test_sel_toggle();
    logic ov, oi, ev, ei, s;
    logic [3:0] oph, eph, p0;
    logic [VW-1:0] od, ed, c;
    logic [VW-1:0] pa = {L{34'h2_AAAA_AAAA}};
    logic [VW-1:0] pb = {L{34'h3_BBBB_BBBB}};
    p0 = 4'(m_ph);
    for (int i = 0; i < 20; i++) begin
      s = 1'(i % 2); c = rand_vec();
      model_beat(1'b1, 1'b0, s, pa, pb, c, 1, ev, ei, eph, ed);
      drive_beat(1'b1, 1'b0, s, pa, pb, c, 1, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL toggle beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
      checks++;
      if (oph !== 4'(p0 + 4'(i))) begin
        errors++; $display("FAIL toggle_phase beat %0d got %0d want %0d", i, oph, 4'(p0 + 4'(i)));
      end
    end
  endtask

  task automatic test_stall();
    logic ov, oi, ev, ei, s, v, fs;
    logic [3:0] oph, eph;
    logic [VW-1:0] od, ed, a, b, c;
    int ninj = 0, inj_at = -1;
    for (int i = 0; i < 31; i++) begin
      v = !(i >= 16 && i < 19); fs = (i == 0); s = 1'($urandom_range(0, 1));
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_beat(v, fs, s, a, b, c, 0, ev, ei, eph, ed);
      drive_beat(v, fs, s, a, b, c, 0, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL stall beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
      if (ov && oi) begin ninj++; inj_at = i; end
    end
    checks++;
    if (ninj != 1 || inj_at != 21) begin
      errors++; $display("FAIL stall_inject got count=%0d at=%0d want count=1 at=21", ninj, inj_at);
    end
  endtask

  task automatic test_sync_abort();
    logic ov, oi, ev, ei, s, fs;
    logic [3:0] oph, eph;
    logic [VW-1:0] od, ed, a, b, c;
    for (int i = 0; i < 36; i++) begin
      fs = (i == 0 || i == 15); s = 1'($urandom_range(0, 1));
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_beat(1'b1, fs, s, a, b, c, 2, ev, ei, eph, ed);
      drive_beat(1'b1, fs, s, a, b, c, 2, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL abort beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
      if (i == 17 || i == 33) begin
        checks++;
        if (oi !== (i == 33) || oph !== 4'd2) begin
          errors++; $display("FAIL abort_inject beat %0d got inj=%b ph=%0d want inj=%b ph=2", i, oi, oph, (i == 33));
        end
      end
    end
  endtask

  task automatic test_random();
    logic ov, oi, ev, ei, s, v, fs;
    logic [3:0] oph, eph;
    logic [VW-1:0] od, ed, a, b, c;
    int cl;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0); fs = ($urandom_range(0, 19) == 0);
      s = 1'($urandom_range(0, 1)); cl = $urandom_range(0, L - 1);
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_beat(v, fs, s, a, b, c, cl, ev, ei, eph, ed);
      drive_beat(v, fs, s, a, b, c, cl, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL random beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
    end
    in_valid = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic test_wide();
    logic [W2-1:0] g2 [L2];
    logic ov, oi, ei;
    logic [4:0] oph;
    logic [VW2-1:0] od, ed;
    int ph, k;
    for (int i = 0; i < L2; i++) g2[i] = '0;
    for (int i = 0; i < 40; i++) begin
      v2 = 1'b1; fs2 = (i == 0); s2 = 1'($urandom_range(0, 1)); cl2 = 3'd3;
      a2 = VW2'(rand_vec()); b2 = VW2'(rand_vec()); c2 = VW2'(rand_vec());
      ph = i % F2; k = (ph - CS2 + F2) % F2;
      ei = (i == 36);
      ed = s2 ? a2 : b2;
      if (ei) for (int j = 0; j < L2; j++) ed[j*W2 +: W2] = g2[j];
      if (k < L2) g2[k] = c2[3*W2 +: W2];
      if (!PIPE) begin #2; ov = ov2; oi = oi2; oph = oph2; od = od2; end
      @(posedge clk); #1;
      if (PIPE) begin ov = ov2; oi = oi2; oph = oph2; od = od2; end
      checks++;
      if ({ov, oi, oph, od} !== {1'b1, ei, 5'(ph), ed}) begin
        errors++; $display("FAIL wide beat %0d: got v=%b inj=%b ph=%0d d=%h want v=1 inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ei, ph, ed);
      end
    end
    v2 = 1'b0; fs2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic ov, oi, ev, ei, s, fs;
    logic [3:0] oph, eph;
    logic [VW-1:0] od, ed, a, b, c;
    int ninj = 0;
    for (int i = 0; i < 15; i++) begin
      fs = (i == 0); s = 1'($urandom_range(0, 1));
      a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_beat(1'b1, fs, s, a, b, c, 0, ev, ei, eph, ed);
      drive_beat(1'b1, fs, s, a, b, c, 0, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL pre_reset beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
    end
    // Mid-cycle, asynchronous to the clock, first window beat already captured.
    in_valid = 0; frame_sync = 0; sel = 0; data_a = '0; data_b = '0; data_c = '0; cap_lane = 0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, inject, phase, data_out} !== '0) begin
      errors++; $display("FAIL async_reset got v=%b inj=%b ph=%0d d=%h want all 0", out_valid, inject, phase, data_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 21; i++) begin
      s = 1'($urandom_range(0, 1)); a = rand_vec(); b = rand_vec(); c = rand_vec();
      model_beat(1'b1, 1'b0, s, a, b, c, 0, ev, ei, eph, ed);
      drive_beat(1'b1, 1'b0, s, a, b, c, 0, ov, oi, oph, od);
      checks++;
      if (ov !== ev || (ev && {oi, oph, od} !== {ei, eph, ed})) begin
        errors++; $display("FAIL post_reset beat %0d: got v=%b inj=%b ph=%0d d=%h want v=%b inj=%b ph=%0d d=%h", i, ov, oi, oph, od, ev, ei, eph, ed);
      end
      if (i < 18 && oi) ninj++;
      if (i == 18) begin
        checks++;
        if (oi !== 1'b1) begin errors++; $display("FAIL post_reset_first_inject got %b want 1", oi); end
      end
    end
    checks++;
    if (ninj != 0) begin errors++; $display("FAIL post_reset_early_inject got %0d want 0", ninj); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gather_basic();
    test_sel_toggle();
    test_stall();
    test_sync_abort();
    test_random();
    test_wide();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
